// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter: grants one of N requesters and holds the grant until the owner releases it.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_bus_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           any_req,
    output logic           timeout
);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("rr_bus_arbiter: N must be in 2..16");
    end
    if (IDW != $clog2(N)) begin : g_bad_idw
        $error("rr_bus_arbiter: IDW must equal clog2(N)");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("rr_bus_arbiter: MAX_HOLD must be >= 2");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [N-1:0]   grant_r;
    logic [N-1:0]   grant_nxt_s;
    logic [IDW-1:0] grant_id_r;
    logic [IDW-1:0] grant_id_nxt_s;
    logic           busy_r;
    logic           busy_nxt_s;
    logic [IDW-1:0] ptr_r;
    logic [IDW-1:0] ptr_nxt_s;
    logic [IDW-1:0] owner_inc_s;
    logic [IDW-1:0] base_s;
    logic [IDW-1:0] win_s;
    logic           found_s;
    logic           normal_rel_s;
    logic           force_s;
    logic           new_grant_s;

    assign any_req  = |req;
    assign grant    = grant_r;
    assign grant_id = grant_id_r;
    assign busy     = busy_r;

    // Pointer value after the current owner releases (owner gets lowest priority).
    always_comb begin
        if (grant_id_r == IDW'(N - 1)) begin
            owner_inc_s = {IDW{1'b0}};
        end else begin
            owner_inc_s = grant_id_r + IDW'(1);
        end
    end

    assign normal_rel_s = done | ~req[grant_id_r];

    // Search base: stored pointer when idle, rotated pointer when re-arbitrating at release.
    always_comb begin
        if (state_r == ST_GRANT) begin
            base_s = owner_inc_s;
        end else begin
            base_s = ptr_r;
        end
    end

    // Round-robin search: first set req bit starting at base_s, wrapping modulo N.
    always_comb begin
        int idx;
        found_s = 1'b0;
        win_s   = {IDW{1'b0}};
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(base_s) + i) % N;
            if (!found_s && req[idx]) begin
                found_s = 1'b1;
                win_s   = idx[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt_s    = state_r;
        grant_nxt_s    = grant_r;
        grant_id_nxt_s = grant_id_r;
        busy_nxt_s     = busy_r;
        ptr_nxt_s      = ptr_r;
        new_grant_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_nxt_s    = ST_GRANT;
                    grant_nxt_s    = {{(N-1){1'b0}}, 1'b1} << win_s;
                    grant_id_nxt_s = win_s;
                    busy_nxt_s     = 1'b1;
                    new_grant_s    = 1'b1;
                end else begin
                    state_nxt_s    = ST_IDLE;
                    grant_nxt_s    = {N{1'b0}};
                    grant_id_nxt_s = {IDW{1'b0}};
                    busy_nxt_s     = 1'b0;
                end
            end
            ST_GRANT: begin
                if (normal_rel_s || force_s) begin
                    ptr_nxt_s = owner_inc_s;
                    if (found_s) begin
                        state_nxt_s    = ST_GRANT;
                        grant_nxt_s    = {{(N-1){1'b0}}, 1'b1} << win_s;
                        grant_id_nxt_s = win_s;
                        busy_nxt_s     = 1'b1;
                        new_grant_s    = 1'b1;
                    end else begin
                        state_nxt_s    = ST_IDLE;
                        grant_nxt_s    = {N{1'b0}};
                        grant_id_nxt_s = {IDW{1'b0}};
                        busy_nxt_s     = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                grant_nxt_s    = {N{1'b0}};
                grant_id_nxt_s = {IDW{1'b0}};
                busy_nxt_s     = 1'b0;
                ptr_nxt_s      = {IDW{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            grant_r    <= {N{1'b0}};
            grant_id_r <= {IDW{1'b0}};
            busy_r     <= 1'b0;
            ptr_r      <= {IDW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            grant_r    <= grant_nxt_s;
            grant_id_r <= grant_id_nxt_s;
            busy_r     <= busy_nxt_s;
            ptr_r      <= ptr_nxt_s;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] hold_cnt_r;
    logic          timeout_r;
    logic          timeout_nxt_s;

    // In the MAX_HOLD-th grant cycle the counter reads MAX_HOLD-1, forcing release at the next edge.
    assign force_s = (state_r == ST_GRANT) && (hold_cnt_r == CW'(MAX_HOLD - 1));

    // A normal release in the same cycle suppresses the timeout pulse.
    always_comb begin
        if (force_s && !normal_rel_s) begin
            timeout_nxt_s = 1'b1;
        end else begin
            timeout_nxt_s = 1'b0;
        end
    end

    // Hold counter and timeout pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_r <= {CW{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            timeout_r <= timeout_nxt_s;
            if (new_grant_s) begin
                hold_cnt_r <= {CW{1'b0}};
            end else if (state_r == ST_GRANT) begin
                hold_cnt_r <= hold_cnt_r + CW'(1);
            end else begin
                hold_cnt_r <= {CW{1'b0}};
            end
        end
    end

    assign timeout = timeout_r;
`else
    logic unused_s;

    assign force_s  = 1'b0;
    assign timeout  = 1'b0;
    assign unused_s = new_grant_s;
`endif

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter sharing one bus or datapath resource between N requesters.
- Combines the request lines into a single "any request" indication and grants exactly one requester at a time.
- Holds the grant until the owner releases it, then rotates priority.
- Sits between requester blocks and the shared resource's enable/select logic.

Parameters:
- N, 4, number of requesters (2..16).
- IDW, 2, width of grant_id; must equal ceil(log2(N)).
- MAX_HOLD, 16, grant-cycle limit used only when ARB_TIMEOUT_EN is defined (>=2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  N  request per requester; level, held until served.
- done  input  1  owner releases the resource this cycle; ignored when no grant is active.
- grant  output  N  one-hot grant, registered; all-zero when idle.
- grant_id  output  IDW  binary index of the current owner, registered; 0 when idle.
- busy  output  1  registered; 1 while any grant is active.
- any_req  output  1  combinational OR of all req bits.
- timeout  output  1  registered 1-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is synchronous and active-low.
- Reset values: grant=0, grant_id=0, busy=0, timeout=0, ptr=0, hold count=0, state=IDLE.
- Reset mid-grant drops grant on that edge; no release handshake is performed.
- ptr: priority pointer. Search order is ptr, ptr+1, ..., wrapping modulo N. The first set req bit in that order wins.
- IDLE state:
  - If any_req at an edge, latch the winner into grant/grant_id, set busy=1, go to GRANT.
  - Latency: req high before edge k gives grant high after edge k (1 cycle).
  - If no request, stay in IDLE with outputs at 0.
- GRANT state:
  - Grant is held while req[owner]=1 and done=0.
  - Release condition: done=1, or req[owner]=0, or a timeout (feature only).
  - On release, set ptr = (owner+1) mod N, then re-arbitrate in the same edge.
  - Re-arbitration searches from the new ptr, so the owner has lowest priority.
  - If any other req is set (or the owner still requests), grant the winner immediately (back-to-back, no dead cycle).
  - If no request remains, clear all outputs and go to IDLE.
- done together with a req drop counts as a single release.
- done while idle has no effect.
- req bits for non-owners change nothing during GRANT.
- A requester dropping req before it is granted is never granted.
- grant is always one-hot or zero. grant_id always matches grant.
- Wrap-around: owner N-1 releases, so ptr becomes 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A hold counter clears on every new grant and increments each GRANT cycle.
  - When the owner has held the grant for MAX_HOLD cycles without releasing, a forced release occurs on the next edge (normal rotation and re-arbitration).
  - timeout pulses high for exactly 1 cycle after that edge.
  - A normal release in the same cycle takes precedence: timeout stays 0.
- When undefined: no counter logic; timeout is tied to 0; grants are held indefinitely.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles: grant=0, busy=0, any_req=0. Then rst_n=0 during GRANT: grant=0 on the next edge.
- From reset, req=4'b0110: edge 1 gives grant=4'b0010, grant_id=1. Then done=1 for 1 cycle: next edge gives grant=4'b0100, grant_id=2 with no idle cycle.
- req=4'b1111 held constant, done pulsed every 3rd cycle: grant sequence 0001, 0010, 0100, 1000, 0001 (wrap). Each grant lasts 3 cycles.
- req=4'b1000 only, owner 3, req[3] dropped: grant=0, busy=0 next edge, ptr=0. Then req=4'b1001: grant=4'b0001.
- Owner 1 asserts done while req[1] stays 1 and no other req: owner 1 is re-granted the next cycle (grant=4'b0010 continuous). done while idle: no change.
- With ARB_TIMEOUT_EN, MAX_HOLD=16, req=4'b0011, no done:
  - Grant 0 is held 16 cycles, then switches to grant=4'b0010 with a single timeout pulse.
  - Without the macro, grant 0 is held for 100+ cycles and timeout stays 0.
